slot_allocator: RTL

- Sequential successor to the combinational slot-fill experiment in the PIM blooming-effect datapath.
- Accepts a batch of N candidate values and scans them one per cycle.
- Writes each nonzero value that is not a duplicate into the lowest-index free slot of an M-entry slot table.
- Slots are freed by an explicit release port. The table persists across batches. Each batch ends with a done pulse and statistics.

---
 rtl/slot_allocator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/slot_allocator.sv
// slot_allocator: scans a latched batch of N candidates one per cycle and
// places each new nonzero value into the lowest free entry of an M-entry
// slot table. The table persists across batches and slots are freed only
// through the release port. Each batch ends with a one-cycle done pulse.
module slot_allocator #(
    parameter int N             = 7,
    parameter int M             = 3,
    parameter int W             = 8,
    parameter int STALL_ON_FULL = 0,
    parameter int IW            = (M > 1) ? $clog2(M) : 1,
    parameter int CW            = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           rel_valid,
    input  logic [IW-1:0]  rel_idx,
    output logic [M*W-1:0] slot_data,
    output logic [M-1:0]   slot_occ,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  alloc_cnt,
    output logic [CW-1:0]  dup_cnt,
    output logic [CW-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [N*W-1:0] batch_q;
    logic [CW-1:0]  idx;
    logic [W-1:0]   cand;
    logic           dup_hit;
    logic           free_hit;
    logic [M-1:0]   free_mask;
    logic [M-1:0]   rel_mask;
    logic [M-1:0]   wr_mask;
    logic           accept;
    logic           hold;
    logic           alloc_en;
    logic           inc_dup;
    logic           inc_drop;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_SCAN);
    assign done     = (state == S_DONE);
    assign accept   = in_valid && in_ready;
    assign wr_mask  = alloc_en ? free_mask : '0;

    // Select the current candidate and match it against the occupied slots.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cand      = '0;
        dup_hit   = 1'b0;
        free_hit  = 1'b0;
        free_mask = '0;
        rel_mask  = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == CW'(i)) cand = batch_q[i*W +: W];
        end
        for (int j = 0; j < M; j++) begin
            if (slot_occ[j] && slot_data[j*W +: W] == cand) dup_hit = 1'b1;
            if (!slot_occ[j] && !free_hit) begin
                free_mask[j] = 1'b1;
                free_hit     = 1'b1;
            end
            // Out-of-range release indices never match any slot.
            if (rel_valid && rel_idx == IW'(j)) rel_mask[j] = 1'b1;
        end
    end

    // Next-state logic and the per-candidate decision while scanning.
    always_comb begin
        state_nx = state;
        hold     = 1'b0;
        alloc_en = 1'b0;
        inc_dup  = 1'b0;
        inc_drop = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = S_SCAN;
            end
            S_SCAN: begin
                if (cand == '0) begin
                    // zero candidates are skipped silently
                end else if (dup_hit) begin
                    inc_dup = 1'b1;
                end else if (free_hit) begin
                    alloc_en = 1'b1;
                end else if (STALL_ON_FULL != 0) begin
                    hold = 1'b1;
                end else begin
                    inc_drop = 1'b1;
                end
                if (!hold && idx == CW'(N - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Batch latch, scan index, statistics and the slot table.
    always_ff @(posedge clk) begin
        // NOTE: the slot table is small and must read as zero after reset, so it is reset like any register.
        if (!rst_n) begin
            batch_q   <= '0;
            idx       <= '0;
            alloc_cnt <= '0;
            dup_cnt   <= '0;
            drop_cnt  <= '0;
            slot_data <= '0;
            slot_occ  <= '0;
        end else begin
            if (accept) begin
                batch_q   <= in_data;
                idx       <= '0;
                alloc_cnt <= '0;
                dup_cnt   <= '0;
                drop_cnt  <= '0;
            end
            if (busy && !hold) idx <= idx + CW'(1);
            if (alloc_en) alloc_cnt <= alloc_cnt + CW'(1);
            if (inc_dup)  dup_cnt   <= dup_cnt + CW'(1);
            if (inc_drop) drop_cnt  <= drop_cnt + CW'(1);
            // Allocation only targets free slots, so it never collides with a
            // meaningful release; the freed slot becomes usable next cycle.
            slot_occ <= (slot_occ & ~rel_mask) | wr_mask;
            for (int j = 0; j < M; j++) begin
                if (wr_mask[j]) slot_data[j*W +: W] <= cand;
            end
        end
    end

endmodule
